// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue: buffers fetched {pc, inst} words and
// hands the oldest to the IDU over valid/ready, absorbing decode stalls.
module if_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic [PC_W-1:0]            in_pc_i,
  input  logic [INST_W-1:0]          in_inst_i,
  output logic                       stallreq_o,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  output logic [PC_W-1:0]            out_pc_o,
  output logic [INST_W-1:0]          out_inst_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic empty, full, push, pop, wr_en, drop;

  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    push  = in_valid_i & ~flush_i;
    pop   = ~empty & out_ready_i & ~flush_i;
    // A full queue still accepts a word in the cycle its head drains.
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order statements execute in.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left unreset; occupancy alone
  // decides validity, and leaving it out keeps the array as plain flops/RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      pc_mem[wptr]   <= in_pc_i;
      inst_mem[wptr] <= in_inst_i;
    end
  end

  always_comb begin
    out_valid_o = ~empty;
    out_pc_o    = empty ? '0 : pc_mem[rptr];
    out_inst_o  = empty ? '0 : inst_mem[rptr];
    stallreq_o  = (count >= CW'(DEPTH - 1));
    count_o     = count;
    overflow_o  = overflow;
  end

endmodule
